// File: rtl/adder_accum.sv
// adder_accum
//   Accumulates a burst of COUNT samples produced by an upstream adder.
//   Each accepted sample is the zero-extended (WIDTH+1)-bit word
//   {in_carry, in_result}. The sum wraps modulo 2^ACC_WIDTH. A sticky
//   overflow flag records any wrap during the burst. The finished sum is
//   offered with a valid/ready handshake.
//
// Parameters
//   WIDTH     : width of the upstream adder result
//   COUNT     : samples per burst (2..256)
//   ACC_WIDTH : accumulator width (>= WIDTH+1)
//
// Ports
//   clk          : rising-edge clock
//   rst          : synchronous active-high reset
//   start        : begin a burst (only looked at in IDLE)
//   in_valid     : upstream sample valid
//   in_ready     : high in every ACCUM cycle
//   in_result    : adder result word
//   in_carry     : adder carry out
//   out_valid    : burst sum available (DONE)
//   out_ready    : downstream takes the sum
//   out_sum      : accumulated sum (holds the last burst while IDLE)
//   out_overflow : sticky wrap flag of that burst
//   busy         : high in ACCUM and DONE
module adder_accum #(
  parameter int WIDTH     = 4,
  parameter int COUNT     = 8,
  parameter int ACC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_result,
  input  logic                 in_carry,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_overflow,
  output logic                 busy
);

  // The counter only has to reach COUNT-1; the last accept moves to DONE.
  localparam int               CNT_W    = (COUNT > 2) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH:0]   sum_ext;

  // Zero-extend {carry, result} to the accumulator width plus one carry bit.
  function automatic logic [ACC_WIDTH:0] extend_sample(
    input logic             carry,
    input logic [WIDTH-1:0] result
  );
    extend_sample = (ACC_WIDTH + 1)'({carry, result});
  endfunction

  // Top bit of the widened sum is the carry out of bit ACC_WIDTH-1.
  always_comb begin
    sum_ext = {1'b0, acc_q} + extend_sample(in_carry, in_result);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end

      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = sum_ext[ACC_WIDTH-1:0];
          ovf_d = ovf_q | sum_ext[ACC_WIDTH];
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      DONE: begin
        out_valid = 1'b1;
        // start is not looked at here, so a start on the handshake cycle
        // is dropped and the earliest restart is the following IDLE cycle.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_sum      = acc_q;
  assign out_overflow = ovf_q;
  assign busy         = (state_q != IDLE);

endmodule
